// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: producer/consumer controls on the
// master side, data and status flags returned from the FIFO on the slave side.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary DEPTH, occupancy count, programmable
// almost flags, FWFT or registered read, synchronous flush and sticky errors.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_fifo_flags_if.slave     bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_r;
    logic             udf_r;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    assign full_w  = (count_r == CW'(DEPTH));
    assign empty_w = (count_r == '0);
    assign wr_acc  = bus.wr_en && !full_w  && !bus.flush;
    assign rd_acc  = bus.rd_en && !empty_w && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.din;
    end

    // A fresh error outranks clr_err; ops squashed by flush never count as errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (bus.wr_en && full_w && !bus.flush)
                ovf_r <= 1'b1;
            else if (bus.clr_err)
                ovf_r <= 1'b0;
            if (bus.rd_en && empty_w && !bus.flush)
                udf_r <= 1'b1;
            else if (bus.clr_err)
                udf_r <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout     = mem[rd_ptr];
            assign bus.rd_valid = !empty_w;
        end else begin : g_reg_read
            logic [WIDTH-1:0] dout_r;
            logic             rd_valid_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_r     <= '0;
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_acc;
                    if (rd_acc) dout_r <= mem[rd_ptr];
                end
            end

            assign bus.dout     = dout_r;
            assign bus.rd_valid = rd_valid_r;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_r >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_r <= CW'(AE_THRESH));
    assign bus.count        = count_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = udf_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: three FIFO instances (DEPTH=16 FWFT, DEPTH=5 FWFT,
// DEPTH=16 registered read) sharing clock and reset.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) fa ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(5))  fb ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) fc ();

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(fa));
    sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(fb));
    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(fc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fa.flush = 0; fa.wr_en = 0; fa.din = 0; fa.rd_en = 0; fa.clr_err = 0;
        fb.flush = 0; fb.wr_en = 0; fb.din = 0; fb.rd_en = 0; fb.clr_err = 0;
        fc.flush = 0; fc.wr_en = 0; fc.din = 0; fc.rd_en = 0; fc.clr_err = 0;
        #12;
        check("rst_empty",  32'(fa.empty), 1);
        check("rst_full",   32'(fa.full), 0);
        check("rst_ae",     32'(fa.almost_empty), 1);
        check("rst_af",     32'(fa.almost_full), 0);
        check("rst_count",  32'(fa.count), 0);
        check("rst_ovf",    32'(fa.overflow), 0);
        check("rst_udf",    32'(fa.underflow), 0);
        check("rst_rdv_c",  32'(fc.rd_valid), 0);
        check("rst_dout_c", 32'(fc.dout), 0);
        rst_n = 1'b1;
        tick();

        // Fill 16 words, flags tracked per edge
        for (int i = 0; i < 16; i++) begin
            fa.wr_en = 1; fa.din = 8'(i);
            tick();
            check($sformatf("fill_cnt%0d", i), 32'(fa.count), 32'(i + 1));
            check($sformatf("fill_af%0d", i),  32'(fa.almost_full), 32'((i + 1) >= 14));
            check($sformatf("fill_ae%0d", i),  32'(fa.almost_empty), 32'((i + 1) <= 2));
            check($sformatf("fill_full%0d", i), 32'(fa.full), 32'((i + 1) == 16));
        end

        // Overflow on full, then clear
        fa.din = 8'hAA;
        tick();
        fa.wr_en = 0;
        check("ovf_set", 32'(fa.overflow), 1);
        check("ovf_cnt", 32'(fa.count), 16);
        fa.clr_err = 1;
        tick();
        fa.clr_err = 0;
        check("ovf_clr", 32'(fa.overflow), 0);

        // Drain in order; 0xAA must not appear
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_d%0d", i), 32'(fa.dout), 32'(i));
            fa.rd_en = 1;
            tick();
        end
        fa.rd_en = 0;
        check("drain_empty", 32'(fa.empty), 1);
        check("drain_cnt",   32'(fa.count), 0);

        // Simultaneous write/read while empty
        fa.wr_en = 1; fa.rd_en = 1; fa.din = 8'h55;
        tick();
        fa.wr_en = 0; fa.rd_en = 0;
        check("wr_rd_empty_cnt",  32'(fa.count), 1);
        check("wr_rd_empty_udf",  32'(fa.underflow), 1);
        check("wr_rd_empty_dout", 32'(fa.dout), 8'h55);
        fa.rd_en = 1;
        tick();
        check("pop55_cnt", 32'(fa.count), 0);
        fa.clr_err = 1;
        tick();
        check("clr_vs_err_udf", 32'(fa.underflow), 1);
        fa.rd_en = 0;
        tick();
        fa.clr_err = 0;
        check("udf_clr", 32'(fa.underflow), 0);

        // DEPTH=5: fill to full, flush, then stream 12 words across the wrap
        for (int i = 0; i < 5; i++) begin
            fb.wr_en = 1; fb.din = 8'(8'h20 + i);
            tick();
        end
        fb.wr_en = 0;
        check("b_full",  32'(fb.full), 1);
        check("b_cnt5",  32'(fb.count), 5);
        check("b_af",    32'(fb.almost_full), 1);
        fb.flush = 1;
        tick();
        fb.flush = 0;
        check("b_flush_empty", 32'(fb.empty), 1);
        fb.wr_en = 1; fb.din = 8'h30;
        tick();
        for (int k = 1; k < 12; k++) begin
            check($sformatf("b_head%0d", k), 32'(fb.dout), 32'(8'h30 + k - 1));
            fb.din = 8'(8'h30 + k); fb.rd_en = 1;
            tick();
            check($sformatf("b_cnt%0d", k), 32'(fb.count), 1);
        end
        fb.wr_en = 0;
        check("b_last", 32'(fb.dout), 8'h3B);
        tick();
        fb.rd_en = 0;
        check("b_empty", 32'(fb.empty), 1);

        // Registered-read instance
        fc.wr_en = 1; fc.din = 8'h11;
        tick();
        fc.din = 8'h22;
        tick();
        fc.wr_en = 0;
        check("c_pre_rdv", 32'(fc.rd_valid), 0);
        fc.rd_en = 1;
        tick();
        fc.rd_en = 0;
        check("c_rdv1",  32'(fc.rd_valid), 1);
        check("c_dout1", 32'(fc.dout), 8'h11);
        tick();
        check("c_rdv0",  32'(fc.rd_valid), 0);
        check("c_hold",  32'(fc.dout), 8'h11);
        fc.rd_en = 1;
        tick();
        fc.rd_en = 0;
        check("c_dout2", 32'(fc.dout), 8'h22);

        // Flush at count 8 with both requests asserted
        for (int i = 0; i < 8; i++) begin
            fa.wr_en = 1; fa.din = 8'(8'h40 + i);
            tick();
        end
        check("pre_flush_cnt", 32'(fa.count), 8);
        fa.flush = 1; fa.rd_en = 1;
        tick();
        fa.flush = 0; fa.wr_en = 0; fa.rd_en = 0;
        check("flush_cnt",   32'(fa.count), 0);
        check("flush_empty", 32'(fa.empty), 1);
        check("flush_ovf",   32'(fa.overflow), 0);
        check("flush_udf",   32'(fa.underflow), 0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            fa.wr_en = 1; fa.din = 8'(i);
            tick();
        end
        fa.rd_en = 1;
        fc.wr_en = 1; fc.din = 8'h77;
        tick();
        rst_n = 1'b0;
        #2;
        check("arst_cnt",    32'(fa.count), 0);
        check("arst_empty",  32'(fa.empty), 1);
        check("arst_ae",     32'(fa.almost_empty), 1);
        check("arst_full",   32'(fa.full), 0);
        check("arst_c_dout", 32'(fc.dout), 0);
        check("arst_c_rdv",  32'(fc.rd_valid), 0);
        check("arst_c_cnt",  32'(fc.count), 0);
        fa.wr_en = 0; fa.rd_en = 0; fc.wr_en = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt", 32'(fa.count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
